irq_timer: RTL and testbench
============================

// Module: irq_timer
// PURPOSE
//  Memory-mapped programmable down-counter that raises a hardware interrupt line.
//  Source end of the CP0 HWint interface: its irq output drives one HWint[7:2] bit.
//  The CPU programs it through a word-addressed register port (sw/lw via bridge).
//  Supports one-shot (held IRQ) and periodic (1-cycle IRQ pulse) modes.
// PARAMETERS
//  CNT_W      32   width of PRESET and COUNT registers (1..32); upper rdata bits read 0
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  reset      in   1      synchronous, active-high
//  addr       in   2      word select: 0=CTRL, 1=PRESET, 2=COUNT (RO), 3=reserved
//  we         in   1      write strobe for addressed register, sampled at clk edge
//  wdata      in   32     write data
//  rdata      out  32     combinational read of addressed register; reserved addr -> 0
//  irq        out  1      interrupt request to CP0 HWint bit; = irq_pend & CTRL.IM
// BEHAVIOUR
//  Registers: CTRL[0]=EN, CTRL[2:1]=MODE (00 one-shot, 01 periodic, 1x = one-shot),
//   CTRL[3]=IM; other CTRL bits read 0. PRESET writable; COUNT read-only (writes ignored).
//  Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_pend=0 -> irq=0, rdata=0 for addr 0.
//  FSM states IDLE, LOAD, CNT, INT (registered, one per cycle):
//   IDLE: hold COUNT. Leave only via CTRL write with EN=1 -> LOAD at that edge.
//   LOAD: COUNT<=PRESET; -> CNT.
//   CNT : COUNT>1 -> COUNT<=COUNT-1, stay. COUNT<=1 -> COUNT<=0, irq_pend<=1, -> INT.
//   INT : one-shot: EN<=0, -> IDLE, irq_pend stays 1.
//         periodic: COUNT<=PRESET, -> CNT, irq_pend<=0 (IRQ = 1-cycle pulse).
//  Latency: CTRL write (EN=1) at edge E0 -> COUNT=PRESET after E1 -> irq high after
//   edge E(1+N), N=max(PRESET,1). Periodic: further pulses every N+1 cycles.
//  PRESET=0 behaves exactly as PRESET=1.
//  irq_pend cleared by any write to CTRL or PRESET (interrupt acknowledge).
//  CTRL write with EN=0 in any state: -> IDLE, COUNT frozen at current value.
//  CTRL write with EN=1 in any state: restarts -> LOAD (re-arm from PRESET).
//  PRESET write while counting: no effect on COUNT until next LOAD/INT reload.
//  Simultaneous CPU write and FSM event on same edge: CPU write wins (state, EN and
//   irq_pend take write result; the FSM transition is discarded).
//  IM=0 masks irq but irq_pend still sets; setting IM later exposes a held pend.
//  Reset mid-count overrides everything; all regs return to reset values next edge.
//  COUNT arithmetic: CNT_W-bit unsigned, never wraps below 0.
// STRUCTURE
//  Shared package timer_pkg: state encoding (IDLE/LOAD/CNT/INT), register word
//   offsets, CTRL bit positions (EN, MODE, IM), MODE encodings.
//  Single module, no sub-modules; read mux and FSM in one file.
// TESTING
//  1 reset, read all addrs -> rdata 0,0,0,0; irq=0.
//  2 PRESET=3, CTRL=0x9 (EN,IM,one-shot) -> irq rises 4 cycles after write, stays high,
//    CTRL reads 0x8; write PRESET -> irq falls next cycle.
//  3 PRESET=2, CTRL=0xB (periodic) -> irq 1-cycle pulses, period 3, COUNT 2,1,0,2,...
//  4 PRESET=10, start, write CTRL=0x8 after 4 cycles -> COUNT frozen at 7, irq never set.
//  5 PRESET=0, CTRL=0x1 (IM=0) -> irq stays 0, pend set; write CTRL=0x8 clears it,
//    write IM without EN after pend via back-door -> irq follows IM.
//  6 CTRL write coincident with INT entry -> write wins, irq=0; reset mid-count -> all 0.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : timer_pkg
//  Description : Shared definitions for the irq_timer block: FSM state
//                encoding, register word offsets, CTRL bit positions and
//                MODE encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    // Register word offsets
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // MODE encodings (1x is treated as one-shot)
    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

endpackage
`default_nettype wire

// File: rtl/irq_timer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : irq_timer_if
//  Description : Word-addressed register port between the CPU bridge
//                (master) and the timer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface irq_timer_if;

    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output addr,
        output we,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  we,
        input  wdata,
        output rdata
    );

endinterface
`default_nettype wire

// File: rtl/irq_timer.sv
`default_nettype none
// ============================================================================
//  Module      : irq_timer
//  Description : Memory-mapped programmable down-counter raising an interrupt
//                line for one CP0 HWint bit. One-shot mode holds the request
//                until acknowledged; periodic mode emits 1-cycle pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_timer
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  wire logic      clk,
    input  wire logic      reset,
    irq_timer_if.slave     bus,
    output logic           irq
);

    state_t             state_q, state_d;
    logic               en_q, en_d;
    logic [1:0]         mode_q, mode_d;
    logic               im_q, im_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               pend_q, pend_d;

    logic               w_wr_ctrl;
    logic               w_wr_preset;
    logic               w_periodic;

    assign w_wr_ctrl   = bus.we && (bus.addr == ADDR_CTRL);
    assign w_wr_preset = bus.we && (bus.addr == ADDR_PRESET);
    assign w_periodic  = (mode_q == MODE_PERIODIC);

    // FSM next state with CPU writes layered on top so a write always wins
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;

        case (state_q)
            ST_IDLE: begin
                count_d = count_q;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    // PRESET of 0 lands here too and behaves like 1
                    count_d = '0;
                    pend_d  = 1'b1;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                if (w_periodic) begin
                    count_d = preset_q;
                    pend_d  = 1'b0;
                    state_d = ST_CNT;
                end else begin
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Any CTRL write discards the FSM step and re-arms or stops the timer
        if (w_wr_ctrl) begin
            en_d    = bus.wdata[CTRL_EN];
            mode_d  = bus.wdata[CTRL_MODE_HI:CTRL_MODE_LO];
            im_d    = bus.wdata[CTRL_IM];
            pend_d  = 1'b0;
            count_d = count_q;
            state_d = bus.wdata[CTRL_EN] ? ST_LOAD : ST_IDLE;
        end

        // PRESET write acknowledges the interrupt; the count keeps running
        if (w_wr_preset) begin
            preset_d = bus.wdata[CNT_W-1:0];
            pend_d   = 1'b0;
        end
    end

    // State and register update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            mode_q   <= MODE_ONESHOT;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

    // Combinational read mux; unused and reserved bits read as zero
    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            ADDR_CTRL:   bus.rdata = {28'd0, im_q, mode_q, en_q};
            ADDR_PRESET: bus.rdata = 32'(preset_q);
            ADDR_COUNT:  bus.rdata = 32'(count_q);
            default:     bus.rdata = '0;
        endcase
    end

    assign irq = pend_q & im_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_timer
//  Description : Directed self-checking bench for irq_timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_timer;

    logic clk;
    logic reset;
    logic irq;

    int   n_total;
    int   n_fail;

    irq_timer_if bus_if ();

    irq_timer #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single-cycle write; the register updates at the next rising edge
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.we    = 1'b1;
        @(posedge clk);
        #1;
        bus_if.we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus_if.addr = a;
        #1;
        d = bus_if.rdata;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] exp_cnt [7];
        logic        exp_irq [7];

        n_total = 0;
        n_fail  = 0;
        bus_if.addr  = 2'd0;
        bus_if.we    = 1'b0;
        bus_if.wdata = 32'd0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;

        // 1: reset state
        rd(2'd0, v); chk("rst_ctrl",   v, 32'd0);
        rd(2'd1, v); chk("rst_preset", v, 32'd0);
        rd(2'd2, v); chk("rst_count",  v, 32'd0);
        rd(2'd3, v); chk("rst_resv",   v, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // 2: one-shot, PRESET=3 -> irq after edge E4
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        tick(3);
        chk("os_irq_early", {31'd0, irq}, 32'd0);
        tick(1);
        chk("os_irq_set", {31'd0, irq}, 32'd1);
        tick(3);
        chk("os_irq_held", {31'd0, irq}, 32'd1);
        rd(2'd0, v); chk("os_ctrl_en_clr", v, 32'h8);
        rd(2'd2, v); chk("os_count_zero", v, 32'd0);
        wr(2'd1, 32'd3);
        chk("os_ack", {31'd0, irq}, 32'd0);

        // 3: periodic, PRESET=2 -> COUNT 2,1,0,... pulse every 3 cycles
        exp_cnt = '{32'd2, 32'd1, 32'd0, 32'd2, 32'd1, 32'd0, 32'd2};
        exp_irq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int i = 0; i < 7; i++) begin
            tick(1);
            rd(2'd2, v);
            chk($sformatf("per_count%0d", i), v, exp_cnt[i]);
            chk($sformatf("per_irq%0d", i), {31'd0, irq}, {31'd0, exp_irq[i]});
        end
        wr(2'd0, 32'h0);

        // 4: stop mid-count freezes COUNT
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        tick(4);
        wr(2'd0, 32'h8);
        rd(2'd2, v); chk("frz_count", v, 32'd7);
        tick(20);
        rd(2'd2, v); chk("frz_count_hold", v, 32'd7);
        chk("frz_irq", {31'd0, irq}, 32'd0);
        rd(2'd0, v); chk("frz_ctrl", v, 32'h8);

        // 5: PRESET=0 acts as 1, IM=0 masks a pending interrupt
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h1);
        tick(1);
        chk("msk_pend_early", {31'd0, dut.pend_q}, 32'd0);
        tick(1);
        chk("msk_pend", {31'd0, dut.pend_q}, 32'd1);
        chk("msk_irq", {31'd0, irq}, 32'd0);
        tick(1);
        rd(2'd0, v); chk("msk_ctrl", v, 32'h0);
        chk("msk_pend_held", {31'd0, dut.pend_q}, 32'd1);
        wr(2'd0, 32'h8);
        chk("msk_pend_ack", {31'd0, dut.pend_q}, 32'd0);
        chk("msk_irq_ack", {31'd0, irq}, 32'd0);
        force dut.pend_q = 1'b1;
        #1;
        chk("bd_irq_im1", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'h0);
        chk("bd_irq_im0", {31'd0, irq}, 32'd0);
        wr(2'd0, 32'h8);
        chk("bd_irq_im1b", {31'd0, irq}, 32'd1);
        release dut.pend_q;
        wr(2'd0, 32'h0);
        chk("bd_clear", {31'd0, dut.pend_q}, 32'd0);

        // 6: CTRL write on the INT-entry edge wins; then reset mid-count
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        tick(2);
        wr(2'd0, 32'h8);
        chk("race_irq", {31'd0, irq}, 32'd0);
        rd(2'd2, v); chk("race_count", v, 32'd1);
        tick(3);
        chk("race_irq_late", {31'd0, irq}, 32'd0);

        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rd(2'd0, v); chk("mrst_ctrl",   v, 32'd0);
        rd(2'd1, v); chk("mrst_preset", v, 32'd0);
        rd(2'd2, v); chk("mrst_count",  v, 32'd0);
        tick(8);
        rd(2'd2, v); chk("mrst_idle", v, 32'd0);
        chk("mrst_irq", {31'd0, irq}, 32'd0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #100000;
        $display("FAIL timeout: observed no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
